ram_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port RAM (registered read, write on the falling clock edge).
- Port A is the processor data side; port B is the I/O/loader side.
- Each requester issues one read or write at a time. The arbiter picks between them round-robin, drives the RAM address/data/write-enable, waits out the RAM read latency, and returns read data with a one-cycle acknowledge.

---
 rtl/ram_arbiter_pkg.sv | 11 +
 rtl/rr_pick2.sv | 13 +
 rtl/ram_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: FSM state encodings and port identifiers shared by the arbiter files.
package ram_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin winner select; the pointer names the port favoured on a tie.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic i_a_req,
  input  logic i_b_req,
  input  logic i_ptr,
  output logic o_grant_valid,
  output logic o_grant_port
);
  assign o_grant_valid = i_a_req | i_b_req;
  assign o_grant_port  = (i_a_req & i_b_req) ? i_ptr : (i_b_req ? PORT_B : PORT_A);
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port sequencer in front of a single-port RAM with
// registered read; every output comes straight from a register.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  A_Req,
  input  logic                  A_Write,
  input  logic [ADDR_WIDTH-1:0] A_Address,
  input  logic [DATA_WIDTH-1:0] A_Write_Data,
  output logic                  A_Ack,
  output logic [DATA_WIDTH-1:0] A_Read_Data,
  input  logic                  B_Req,
  input  logic                  B_Write,
  input  logic [ADDR_WIDTH-1:0] B_Address,
  input  logic [DATA_WIDTH-1:0] B_Write_Data,
  output logic                  B_Ack,
  output logic [DATA_WIDTH-1:0] B_Read_Data,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data,
  output logic                  Mem_Write,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data,
  output logic                  Busy
);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t r_state, w_state;
  logic r_ptr, w_ptr, r_port, w_port, r_op, w_op, r_mwr, w_mwr;
  logic r_a_ack, r_b_ack, r_busy, w_gv, w_gp;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata, r_a_rd, w_a_rd, r_b_rd, w_b_rd;

  rr_pick2 u_pick (
    .i_a_req      (A_Req),
    .i_b_req      (B_Req),
    .i_ptr        (r_ptr),
    .o_grant_valid(w_gv),
    .o_grant_port (w_gp)
  );

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_port  = r_port;
    w_op    = r_op;
    w_cnt   = r_cnt;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_mwr   = 1'b0;
    w_a_rd  = r_a_rd;
    w_b_rd  = r_b_rd;
    case (r_state)
      ST_IDLE: if (w_gv) begin
        w_state = ST_ACCESS;
        w_port  = w_gp;
        w_ptr   = ~w_gp;
        w_op    = w_gp ? B_Write : A_Write;
        w_addr  = w_gp ? B_Address : A_Address;
        w_wdata = w_gp ? B_Write_Data : A_Write_Data;
        w_mwr   = w_op;
      end
      ST_ACCESS: begin
        w_state = r_op ? ST_ACK : ST_WAIT;
        w_cnt   = CW'(READ_LATENCY - 1);
      end
      ST_WAIT: if (r_cnt == '0) begin
        w_state = ST_ACK;
        w_a_rd  = (r_port == PORT_A) ? Mem_Read_Data : r_a_rd;
        w_b_rd  = (r_port == PORT_B) ? Mem_Read_Data : r_b_rd;
      end else begin
        w_cnt = r_cnt - CW'(1);
      end
      ST_ACK: w_state = ST_IDLE;
    endcase
  end

  // Ack and Busy are registered from the next state so they line up with the state itself.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= PORT_A;
      r_port  <= PORT_A;
      r_op    <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mwr   <= 1'b0;
      r_a_rd  <= '0;
      r_b_rd  <= '0;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_port  <= w_port;
      r_op    <= w_op;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_mwr   <= w_mwr;
      r_a_rd  <= w_a_rd;
      r_b_rd  <= w_b_rd;
      r_a_ack <= (w_state == ST_ACK) && (w_port == PORT_A);
      r_b_ack <= (w_state == ST_ACK) && (w_port == PORT_B);
      r_busy  <= (w_state != ST_IDLE);
    end
  end

  assign A_Ack          = r_a_ack;
  assign B_Ack          = r_b_ack;
  assign A_Read_Data    = r_a_rd;
  assign B_Read_Data    = r_b_rd;
  assign Mem_Address    = r_addr;
  assign Mem_Write_Data = r_wdata;
  assign Mem_Write      = r_mwr;
  assign Busy           = r_busy;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized self-checking bench; RAM models plus a transaction-level
// reference (memory array and round-robin pointer) predict grant order and read data.
module tb_ram_arbiter;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        clr = 1'b1;
  logic        A_Req = 1'b0, A_Write = 1'b0, B_Req = 1'b0, B_Write = 1'b0;
  logic [15:0] A_Address = '0, B_Address = '0, Mem_Address;
  logic [31:0] A_Write_Data = '0, B_Write_Data = '0, Mem_Write_Data, Mem_Read_Data;
  logic [31:0] A_Read_Data, B_Read_Data;
  logic        A_Ack, B_Ack, Mem_Write, Busy;

  logic        B3_Req = 1'b0;
  logic [15:0] B3_Address = '0, Mem3_Address;
  logic [31:0] Mem3_Write_Data, Mem3_Read_Data, A3_Read_Data, B3_Read_Data;
  logic        A3_Ack, B3_Ack, Mem3_Write, Busy3;

  logic [31:0] mem [256];
  logic [31:0] mem3 [16];
  logic [31:0] p3 [3];
  logic [31:0] model_mem [256];
  bit          mptr;
  int          checks = 0, passed = 0;

  always #5 Clock = ~Clock;

  ram_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .A_Req(A_Req), .A_Write(A_Write), .A_Address(A_Address), .A_Write_Data(A_Write_Data),
    .A_Ack(A_Ack), .A_Read_Data(A_Read_Data),
    .B_Req(B_Req), .B_Write(B_Write), .B_Address(B_Address), .B_Write_Data(B_Write_Data),
    .B_Ack(B_Ack), .B_Read_Data(B_Read_Data),
    .Mem_Address(Mem_Address), .Mem_Write_Data(Mem_Write_Data), .Mem_Write(Mem_Write),
    .Mem_Read_Data(Mem_Read_Data), .Busy(Busy)
  );

  ram_arbiter #(.READ_LATENCY(3)) dut3 (
    .Clock(Clock), .Reset(Reset),
    .A_Req(1'b0), .A_Write(1'b0), .A_Address(16'h0), .A_Write_Data(32'h0),
    .A_Ack(A3_Ack), .A_Read_Data(A3_Read_Data),
    .B_Req(B3_Req), .B_Write(1'b0), .B_Address(B3_Address), .B_Write_Data(32'h0),
    .B_Ack(B3_Ack), .B_Read_Data(B3_Read_Data),
    .Mem_Address(Mem3_Address), .Mem_Write_Data(Mem3_Write_Data), .Mem_Write(Mem3_Write),
    .Mem_Read_Data(Mem3_Read_Data), .Busy(Busy3)
  );

  // Single-port RAM: writes on the falling edge, registered read.
  always @(negedge Clock) begin
    if (clr) for (int i = 0; i < 256; i++) mem[i] = '0;
    else if (Mem_Write) mem[Mem_Address[7:0]] = Mem_Write_Data;
  end
  always @(posedge Clock) Mem_Read_Data <= mem[Mem_Address[7:0]];

  // Three-stage read pipeline for the long-latency instance.
  always @(posedge Clock) begin
    p3[0] <= mem3[Mem3_Address[3:0]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign Mem3_Read_Data = p3[2];

  task automatic test_reset();
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({A_Ack, B_Ack, Busy, Mem_Write, Mem_Address, Mem_Write_Data, A_Read_Data, B_Read_Data} !== '0)
      $display("FAIL reset_hold outputs=%h required 0", {A_Ack, B_Ack, Busy, Mem_Write, Mem_Address, Mem_Write_Data, A_Read_Data, B_Read_Data});
    else passed++;
    @(posedge Clock); #1 Reset = 1'b1;
    clr = 1'b0;
    @(negedge Clock);
    checks++;
    if ({A_Ack, B_Ack, Busy, Mem_Write, Mem_Address, Mem_Write_Data, A_Read_Data, B_Read_Data} !== '0)
      $display("FAIL reset_release outputs=%h required 0", {A_Ack, B_Ack, Busy, Mem_Write, Mem_Address, Mem_Write_Data, A_Read_Data, B_Read_Data});
    else passed++;
    checks++;
    if ({A3_Ack, B3_Ack, Busy3, Mem3_Write, A3_Read_Data, B3_Read_Data} !== '0)
      $display("FAIL reset_lat3 outputs=%h required 0", {A3_Ack, B3_Ack, Busy3, Mem3_Write, A3_Read_Data, B3_Read_Data});
    else passed++;
    mptr = 1'b0;
  endtask

  task automatic run_pair(input bit ra, input bit rb,
                          input bit wa, input logic [15:0] aa, input logic [31:0] da,
                          input bit wb, input logic [15:0] ab, input logic [31:0] db,
                          input string nm);
    bit exp_q[$];
    bit mw[8];
    bit p, wr, ovl;
    int need, got, c;
    logic [15:0] ad;
    logic [31:0] dd, rd, a0, b0;
    need = int'(ra) + int'(rb);
    if (ra && rb) begin exp_q.push_back(mptr); exp_q.push_back(~mptr); end
    else exp_q.push_back(rb);
    @(posedge Clock); #1;
    A_Write = wa; A_Address = aa; A_Write_Data = da; A_Req = ra;
    B_Write = wb; B_Address = ab; B_Write_Data = db; B_Req = rb;
    a0 = A_Read_Data; b0 = B_Read_Data;
    got = 0; c = 0; ovl = 1'b0;
    while (got < need && c < 20) begin
      @(negedge Clock);
      if (c < 8) mw[c] = Mem_Write;
      if (A_Ack && B_Ack) ovl = 1'b1;
      if (A_Ack || B_Ack) begin
        p = B_Ack;
        checks++;
        if (p !== exp_q[got]) $display("FAIL %s order ack_port=%0d required %0d", nm, p, exp_q[got]);
        else passed++;
        if (got == 0 && need == 2) begin
          checks++;
          if ((p ? A_Read_Data : B_Read_Data) !== (p ? a0 : b0))
            $display("FAIL %s idle_port_rdata got=%h required %h", nm, p ? A_Read_Data : B_Read_Data, p ? a0 : b0);
          else passed++;
        end
        wr = p ? wb : wa; ad = p ? ab : aa; dd = p ? db : da;
        rd = p ? B_Read_Data : A_Read_Data;
        if (wr) model_mem[ad[7:0]] = dd;
        else begin
          checks++;
          if (rd !== model_mem[ad[7:0]]) $display("FAIL %s rdata got=%h required %h", nm, rd, model_mem[ad[7:0]]);
          else passed++;
        end
        if (need == 1) begin
          checks++;
          if (c !== (wr ? 2 : 3)) $display("FAIL %s latency got=%0d required %0d", nm, c, wr ? 2 : 3);
          else passed++;
        end
        mptr = ~p;
        got++;
        @(posedge Clock); #1;
        if (p) B_Req = 1'b0; else A_Req = 1'b0;
      end
      c++;
    end
    checks++;
    if (got != need) $display("FAIL %s timeout acks=%0d required %0d", nm, got, need);
    else passed++;
    checks++;
    if (ovl !== 1'b0) $display("FAIL %s ack_overlap got=%0d required 0", nm, ovl);
    else passed++;
    if (need == 1 && (ra ? wa : wb)) begin
      checks++;
      if ({mw[0], mw[1], mw[2]} !== 3'b010) $display("FAIL %s mem_write_window got=%b required 010", nm, {mw[0], mw[1], mw[2]});
      else passed++;
    end
    A_Req = 1'b0; B_Req = 1'b0;
  endtask

  task automatic test_simultaneous();
    run_pair(1, 1, 1, 16'h0001, 32'h11, 1, 16'h0002, 32'h22, "sim_wr");
    run_pair(1, 1, 0, 16'h0001, 32'h0, 0, 16'h0002, 32'h0, "sim_rd");
  endtask

  task automatic test_write_read();
    run_pair(1, 0, 1, 16'h0010, 32'hDEADBEEF, 0, 16'h0, 32'h0, "wr_a");
    run_pair(1, 0, 0, 16'h0010, 32'h0, 0, 16'h0, 32'h0, "rd_a");
  endtask

  task automatic test_back_to_back();
    int n, idle, c, bad_gap;
    bit p, ovl, bad_order, bad_data;
    @(posedge Clock); #1;
    A_Write = 1'b0; A_Address = 16'h0001; B_Write = 1'b0; B_Address = 16'h0002;
    A_Req = 1'b1; B_Req = 1'b1;
    n = 0; idle = 0; c = 0; bad_gap = 0; ovl = 0; bad_order = 0; bad_data = 0;
    while (n < 8 && c < 60) begin
      @(negedge Clock);
      if (!Busy) idle++;
      if (A_Ack && B_Ack) ovl = 1'b1;
      if (A_Ack || B_Ack) begin
        p = B_Ack;
        if (p !== mptr) bad_order = 1'b1;
        if (n > 0 && idle != 1) bad_gap++;
        if ((p ? B_Read_Data : A_Read_Data) !== model_mem[p ? 2 : 1]) bad_data = 1'b1;
        idle = 0;
        mptr = ~p;
        n++;
        if (n == 8) begin @(posedge Clock); #1 A_Req = 1'b0; B_Req = 1'b0; end
      end
      c++;
    end
    A_Req = 1'b0; B_Req = 1'b0;
    checks++;
    if (n != 8) $display("FAIL b2b count got=%0d required 8", n); else passed++;
    checks++;
    if (bad_order) $display("FAIL b2b order got=not_alternating required A,B,A,B"); else passed++;
    checks++;
    if (bad_gap != 0) $display("FAIL b2b idle_gap bad_gaps=%0d required 0", bad_gap); else passed++;
    checks++;
    if (ovl) $display("FAIL b2b ack_overlap got=1 required 0"); else passed++;
    checks++;
    if (bad_data) $display("FAIL b2b rdata got=wrong required model data"); else passed++;
  endtask

  task automatic test_random();
    int m;
    for (int i = 0; i < 16; i++) begin
      m = $urandom_range(1, 3);
      run_pair(m[0], m[1],
               1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom,
               1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom, "rand");
    end
  endtask

  task automatic test_latency3();
    int c, hit;
    bit addr_ok;
    logic [31:0] v;
    v = $urandom;
    mem3[5] = v;
    @(posedge Clock); #1;
    B3_Address = 16'h0005; B3_Req = 1'b1;
    c = 0; hit = -1; addr_ok = 1'b1;
    while (c < 12 && hit < 0) begin
      @(negedge Clock);
      if (c >= 1 && c <= 4 && Mem3_Address !== 16'h0005) addr_ok = 1'b0;
      if (B3_Ack) hit = c;
      c++;
    end
    @(posedge Clock); #1 B3_Req = 1'b0;
    checks++;
    if (hit != 5) $display("FAIL lat3 ack_cycle got=%0d required 5", hit); else passed++;
    checks++;
    if (!addr_ok) $display("FAIL lat3 addr_hold got=changed required 0005"); else passed++;
    checks++;
    if (B3_Read_Data !== v) $display("FAIL lat3 rdata got=%h required %h", B3_Read_Data, v); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bit acked;
    d = $urandom;
    @(posedge Clock); #1;
    A_Write = 1'b1; A_Address = 16'h0020; A_Write_Data = d; A_Req = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if ({A_Ack, Busy, Mem_Write} !== 3'b000) $display("FAIL rst_wr ack_busy_mw got=%b required 000", {A_Ack, Busy, Mem_Write});
    else passed++;
    A_Req = 1'b0;
    @(posedge Clock); #1 Reset = 1'b1;
    model_mem[8'h20] = d;
    mptr = 1'b0;
    @(posedge Clock); #1;
    A_Write = 1'b0; A_Req = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    @(negedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if ({A_Ack, Busy, Mem_Write, A_Read_Data} !== '0)
      $display("FAIL rst_rd outputs got=%h required 0", {A_Ack, Busy, Mem_Write, A_Read_Data});
    else passed++;
    A_Req = 1'b0;
    @(posedge Clock); #1 Reset = 1'b1;
    acked = 1'b0;
    repeat (3) begin @(negedge Clock); if (A_Ack || B_Ack || Busy) acked = 1'b1; end
    checks++;
    if (acked) $display("FAIL rst_quiet activity got=1 required 0"); else passed++;
    run_pair(1, 1, 0, 16'h0020, 32'h0, 0, 16'h0002, 32'h0, "rst_after");
  endtask

  initial begin
    foreach (model_mem[i]) model_mem[i] = '0;
    foreach (mem3[i]) mem3[i] = '0;
    test_reset();
    test_simultaneous();
    test_back_to_back();
    test_write_read();
    test_random();
    test_latency3();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
